// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Accepts a parallel byte over a valid/ready handshake and shifts it out
//   MSB first on a single-bit stream. Each bit is held for CLK_DIV cycles.
//   A new byte may be accepted in the final cycle of a frame's last bit, so
//   back-to-back frames run with no idle gap.
//
//   Optional feature: define SER_PARITY_EN to append an even-parity bit
//   (XOR of the eight data bits) after din[0]. Frames are then nine bits long,
//   and the ready window moves to the parity bit's final cycle.
//
//   All outputs come straight from flops. Their next values are derived from
//   the next-state values, so no combinational path runs from din to sout.
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       busy
);

    // Divide counter runs 0..CLK_DIV-1; bit advances on terminal count.
    localparam int unsigned           DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);

`ifdef SER_PARITY_EN
    // Nine-bit frame: data bits 0..7, parity bit at index 8.
    localparam int unsigned           BIT_W    = 4;
    localparam logic [BIT_W-1:0]      BIT_LAST = 4'd8;
`else
    // Eight-bit frame: a 3-bit index covers it exactly.
    localparam int unsigned           BIT_W    = 3;
    localparam logic [BIT_W-1:0]      BIT_LAST = 3'd7;
`endif
    localparam logic [BIT_W-1:0]      BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef SER_PARITY_EN
    // Even parity over the data byte: the appended bit makes the total
    // number of ones in the nine-bit frame even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [7:0]         shreg_q,      shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q,    div_cnt_d;
`ifdef SER_PARITY_EN
    logic               parity_q,     parity_d;
`endif

    // Registered outputs
    logic               sout_q,       sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               busy_q,       busy_d;
    logic               din_ready_q,  din_ready_d;

    // Handshake and decode helpers
    logic               accept_s;
    logic               div_tc_s;
    logic               last_bit_s;
    logic               cur_bit_s;

    // A byte is taken only when the producer offers it and ready is
    // already showing; ready is a flop, so this never depends on din_valid
    // feeding back into itself.
    assign accept_s   = din_valid && din_ready_q;
    assign div_tc_s   = (div_cnt_q == DIV_LAST);
    assign last_bit_s = (bit_cnt_q == BIT_LAST);

    // Next-state logic: load on accept, count within a bit, step bits,
    // and either chain into the next frame or fall back to IDLE.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
`ifdef SER_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = din;
                    bit_cnt_d = BIT_ZERO;
                    div_cnt_d = DIV_ZERO;
`ifdef SER_PARITY_EN
                    parity_d  = even_parity(din);
`endif
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!div_tc_s) begin
                    // Still holding the current bit.
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end else if (!last_bit_s) begin
                    // Terminal count of a non-final bit: step to the next one.
                    div_cnt_d = DIV_ZERO;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                end else if (accept_s) begin
                    // Final cycle of the frame and a new byte arrives:
                    // chain straight into the next frame.
                    state_d   = ST_SHIFT;
                    shreg_d   = din;
                    bit_cnt_d = BIT_ZERO;
                    div_cnt_d = DIV_ZERO;
`ifdef SER_PARITY_EN
                    parity_d  = even_parity(din);
`endif
                end else begin
                    // Frame complete with nothing waiting.
                    state_d   = ST_IDLE;
                    shreg_d   = 8'h00;
                    bit_cnt_d = BIT_ZERO;
                    div_cnt_d = DIV_ZERO;
`ifdef SER_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = 8'h00;
                bit_cnt_d = BIT_ZERO;
                div_cnt_d = DIV_ZERO;
`ifdef SER_PARITY_EN
                parity_d  = 1'b0;
`endif
            end
        endcase
    end

    // Output decode from the next state, so each output flop carries exactly
    // what the state registers will represent after the same edge.
    always_comb begin
`ifdef SER_PARITY_EN
        if (bit_cnt_d == BIT_LAST) begin
            cur_bit_s = parity_d;
        end else begin
            cur_bit_s = shreg_d[7];
        end
`else
        cur_bit_s = shreg_d[7];
`endif
        if (state_d == ST_SHIFT) begin
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
            sout_d       = cur_bit_s;
            din_ready_d  = (div_cnt_d == DIV_LAST) && (bit_cnt_d == BIT_LAST);
        end else begin
            // IDLE drives a quiet zero so the downstream detector sees nothing.
            sout_valid_d = 1'b0;
            busy_d       = 1'b0;
            sout_d       = 1'b0;
            din_ready_d  = 1'b1;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= BIT_ZERO;
            div_cnt_q    <= DIV_ZERO;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            din_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            din_ready_q  <= din_ready_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign din_ready  = din_ready_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Two instances (CLK_DIV=1 and CLK_DIV=4) driven by directed and random
//   stimulus. A reference model keeps, per instance, the queue of serial bits
//   still to appear on sout; every cycle the outputs are compared with it.
//   Honours SER_PARITY_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din1, din4;
    logic       v1, v4;
    logic       rdy1, rdy4, so1, so4, sv1, sv4, bz1, bz4;

    int checks = 0;
    int errors = 0;

    // Model: bits still to be shown; front entry is the current cycle's bit.
    bit q1[$];
    bit q4[$];
    bit acc1, acc4;

    bit_serializer #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .busy(bz1)
    );

    bit_serializer #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(rdy4),
        .sout(so4), .sout_valid(sv4), .busy(bz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame bits, most significant first starting at index NB-1.
    function automatic logic [8:0] fr_bits(input logic [7:0] b);
`ifdef SER_PARITY_EN
        return {b, ^b};
`else
        return {1'b0, b};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then compare outputs.
    task automatic tick();
        logic [8:0] f;
        bit         e_v1, e_s1, e_v4, e_s4;
        @(posedge clk);
        acc1 = 1'b0;
        acc4 = 1'b0;
        if (rst) begin
            q1.delete();
            q4.delete();
        end else begin
            acc1 = v1 && (q1.size() <= 1);
            acc4 = v4 && (q4.size() <= 1);
            if (q1.size() != 0) void'(q1.pop_front());
            if (q4.size() != 0) void'(q4.pop_front());
            if (acc1) begin
                f = fr_bits(din1);
                for (int b = NB - 1; b >= 0; b--) q1.push_back(f[b]);
            end
            if (acc4) begin
                f = fr_bits(din4);
                for (int b = NB - 1; b >= 0; b--)
                    for (int c = 0; c < 4; c++) q4.push_back(f[b]);
            end
        end
        #1;
        e_v1 = (q1.size() != 0);
        e_s1 = e_v1 ? q1[0] : 1'b0;
        e_v4 = (q4.size() != 0);
        e_s4 = e_v4 ? q4[0] : 1'b0;
        chk("d1_sout",       so1,  e_s1);
        chk("d1_sout_valid", sv1,  e_v1);
        chk("d1_busy",       bz1,  e_v1);
        chk("d1_din_ready",  rdy1, q1.size() <= 1);
        chk("d4_sout",       so4,  e_s4);
        chk("d4_sout_valid", sv4,  e_v4);
        chk("d4_busy",       bz4,  e_v4);
        chk("d4_din_ready",  rdy4, q4.size() <= 1);
    endtask

    task automatic send1(input logic [7:0] b);
        din1 = b;
        v1   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc1) break;
        end
        chk("d1_accept", acc1, 1'b1);
        v1 = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        din4 = b;
        v4   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc4) break;
        end
        chk("d4_accept", acc4, 1'b1);
        v4 = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int         cnt, ones, rcnt, n;

        rst = 1'b1; v1 = 1'b0; v4 = 1'b0; din1 = 8'h00; din4 = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // A5 at one cycle per bit: exact stream, then idle.
        send1(8'hA5);
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], so1};
            tick();
        end
        chk("a5_stream", r, 8'hA5);
`ifdef SER_PARITY_EN
        chk("a5_parity", so1, 1'b0);
        tick();
`endif
        chk("a5_idle_sout", so1, 1'b0);
        chk("a5_idle_busy", bz1, 1'b0);

        // 0x80 at four cycles per bit: valid length and ones count.
        send4(8'h80);
        cnt  = 0;
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            if (!sv4) break;
            cnt++;
            if (so4) ones++;
            tick();
        end
        chk("x80_valid_cycles", cnt, NB * 4);
`ifdef SER_PARITY_EN
        chk("x80_high_cycles", ones, 8);
`else
        chk("x80_high_cycles", ones, 4);
`endif

        // 05 then 0A back-to-back: continuous valid, ready only at frame ends.
        send1(8'h05);
        din1 = 8'h0A;
        v1   = 1'b1;
        cnt  = 0;
        rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!sv1) break;
            cnt++;
            if (rdy1) rcnt++;
            tick();
            if (acc1) v1 = 1'b0;
        end
        chk("b2b_valid_cycles", cnt, 2 * NB);
        chk("b2b_ready_cycles", rcnt, 2);

        // Producer holds valid while din churns; only window captures count.
        n  = 0;
        v4 = 1'b1;
        din4 = 8'($urandom);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc4) n++;
            if (n == 2) break;
            din4 = 8'($urandom);
        end
        v4 = 1'b0;
        chk("hold_accepts", n, 2);
        for (int i = 0; i < 4 * NB + 2; i++) tick();

        // Reset in the middle of FF, with a byte offered on the reset edge.
        send1(8'hFF);
        tick(); tick(); tick();
        rst  = 1'b1;
        v1   = 1'b1;
        din1 = 8'h55;
        tick();
        rst = 1'b0;
        v1  = 1'b0;
        chk("rst_sout",       so1,  1'b0);
        chk("rst_sout_valid", sv1,  1'b0);
        chk("rst_din_ready",  rdy1, 1'b1);
        tick();
        send1(8'h01);
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], so1};
            tick();
        end
        chk("x01_stream", r, 8'h01);
`ifdef SER_PARITY_EN
        chk("x01_parity", so1, 1'b1);
        tick();
`endif
        chk("x01_idle_valid", sv1, 1'b0);

        // Random traffic with occasional resets on both instances.
        for (int i = 0; i < 800; i++) begin
            v1   = 1'($urandom_range(0, 1));
            v4   = 1'($urandom_range(0, 1));
            din1 = 8'($urandom);
            din4 = 8'($urandom);
            rst  = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        v1  = 1'b0;
        v4  = 1'b0;
        for (int i = 0; i < 4 * NB + 4; i++) tick();
        chk("drain_d1_idle", sv1, 1'b0);
        chk("drain_d4_idle", sv4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
